// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared constants and special-value helpers for the posit datapath
package posit_pkg;

    localparam int DEF_BITS = 32;
    localparam int DEF_ES   = 3;

    // Extended body holds regime (<= BITS-1 bits), exponent and full fraction plus padding.
    localparam int DEF_EXT_W = 2 * DEF_BITS + DEF_ES;

    function automatic int posit_ext_width(input int bits, input int es);
        return 2 * bits + es;
    endfunction

    function automatic logic [63:0] posit_maxpos(input int bits);
        return (64'd1 << (bits - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] posit_minpos(input int bits);
        return (bits > 0) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] posit_nar(input int bits);
        return 64'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/posit_round_nearest_even.sv
// rtl/posit_round_nearest_even.sv - RNE rounding with posit saturation from an extended body to a final word
module posit_round_nearest_even
    import posit_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int ES   = DEF_ES
) (
    input  logic [2*BITS+ES-1:0] ext,
    input  logic                 sign,
    input  logic                 sat_max,
    input  logic                 sat_min,
    input  logic                 nar,
    input  logic                 zero,
    output logic [BITS-1:0]      word
);

    localparam int          EXT_W  = posit_ext_width(BITS, ES);
    localparam logic [63:0] MAXP64 = posit_maxpos(BITS);
    localparam logic [63:0] MINP64 = posit_minpos(BITS);
    localparam logic [63:0] NAR64  = posit_nar(BITS);

    logic [BITS-2:0] body;
    logic [BITS-2:0] rounded;
    logic            guard;
    logic            sticky;
    logic            round_up;
    logic [BITS-1:0] mag;

    always_comb begin
        body     = ext[EXT_W-1 -: BITS-1];
        guard    = ext[EXT_W-BITS];
        sticky   = |ext[EXT_W-BITS-1:0];
        round_up = guard && (sticky || body[0]);

        // An all-ones body is maxpos already; a carry out would wrap into the sign bit.
        if (round_up && (&body)) begin
            rounded = body;
        end else begin
            rounded = body + {{(BITS-2){1'b0}}, round_up};
        end

        mag = {1'b0, rounded};
        if (sat_max) begin
            mag = MAXP64[BITS-1:0];
        end else if (sat_min || (rounded == '0)) begin
            mag = MINP64[BITS-1:0];
        end

        word = sign ? -mag : mag;
        if (nar) begin
            word = NAR64[BITS-1:0];
        end else if (zero) begin
            word = '0;
        end
    end

endmodule

// File: rtl/posit_packer.sv
// rtl/posit_packer.sv - two-stage packer from decoded posit fields to a rounded posit word
module posit_packer
    import posit_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int ES   = DEF_ES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sign,
    input  logic                         in_zero,
    input  logic                         in_nar,
    input  logic [BITS-1:0]              in_seed,
    input  logic [((ES > 0) ? ES : 1)-1:0] in_exp,
    input  logic [BITS-1:0]              in_frac,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BITS-1:0]              out_data
);

    localparam int EXT_W = posit_ext_width(BITS, ES);
    localparam logic signed [BITS-1:0] K_MAX = BITS'(BITS - 2);
    localparam logic signed [BITS-1:0] K_MIN = BITS'(-(BITS - 1));

    logic             en;
    logic             k_neg;
    logic             sat_max_c;
    logic             sat_min_c;
    logic [1:0]       top2;
    logic [BITS-1:0]  shamt;
    logic [EXT_W-1:0] base;
    logic [EXT_W-1:0] ext_c;

    logic             s1_valid;
    logic [EXT_W-1:0] s1_ext;
    logic             s1_sign;
    logic             s1_nar;
    logic             s1_zero;
    logic             s1_sat_max;
    logic             s1_sat_min;
    logic [BITS-1:0]  word;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign k_neg     = in_seed[BITS-1];
    assign sat_max_c = $signed(in_seed) >= K_MAX;
    assign sat_min_c = $signed(in_seed) <= K_MIN;

    // Seed the regime with its last run bit and terminator, then let the arithmetic shift
    // replicate the run bit: k>=0 gives k+1 ones then 0, k<0 gives -k zeros then 1.
    assign top2  = k_neg ? 2'b01 : 2'b10;
    assign shamt = k_neg ? ~in_seed : in_seed;

    if (ES > 0) begin : g_exp
        assign base = {top2, in_exp, in_frac, {(BITS-2){1'b0}}};
    end else begin : g_noexp
        assign base = {top2, in_frac, {(BITS-2){1'b0}}};
    end

    assign ext_c = $signed(base) >>> shamt;

    posit_round_nearest_even #(
        .BITS (BITS),
        .ES   (ES)
    ) u_round (
        .ext     (s1_ext),
        .sign    (s1_sign),
        .sat_max (s1_sat_max),
        .sat_min (s1_sat_min),
        .nar     (s1_nar),
        .zero    (s1_zero),
        .word    (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_ext     <= '0;
            s1_sign    <= 1'b0;
            s1_nar     <= 1'b0;
            s1_zero    <= 1'b0;
            s1_sat_max <= 1'b0;
            s1_sat_min <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else if (en) begin
            s1_valid   <= in_valid;
            s1_ext     <= ext_c;
            s1_sign    <= in_sign;
            s1_nar     <= in_nar;
            s1_zero    <= in_zero;
            s1_sat_max <= sat_max_c;
            s1_sat_min <= sat_min_c;
            out_valid  <= s1_valid;
            out_data   <= word;
        end
    end

endmodule

// File: tb/tb_posit_packer.sv
// tb/tb_posit_packer.sv - self-checking bench for posit_packer at 8/1 and 32/3
module tb_posit_packer;

    logic        clk;
    logic        rst_n;

    logic        iv, ir, sgn, zr, nr, ov, ordy;
    logic [7:0]  seed, fr, od;
    logic [0:0]  ex;

    logic        iv32, ir32, sgn32, ov32, or32;
    logic [31:0] seed32, fr32, od32;
    logic [2:0]  ex32;

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic              s;
        logic              z;
        logic              n;
        logic signed [7:0] k;
        logic              e;
        logic [7:0]        f;
        logic [7:0]        x;
    } vec_t;

    vec_t tbl [12] = '{
        '{1'b0, 1'b0, 1'b0,   8'sd0, 1'b0, 8'h00, 8'h40},
        '{1'b1, 1'b0, 1'b0,   8'sd0, 1'b0, 8'h00, 8'hC0},
        '{1'b0, 1'b0, 1'b0,  -8'sd1, 1'b1, 8'h80, 8'h38},
        '{1'b0, 1'b0, 1'b0,  8'sd10, 1'b0, 8'h00, 8'h7F},
        '{1'b0, 1'b0, 1'b0, -8'sd10, 1'b0, 8'h00, 8'h01},
        '{1'b1, 1'b0, 1'b0, -8'sd10, 1'b0, 8'h00, 8'hFF},
        '{1'b0, 1'b0, 1'b0,   8'sd0, 1'b0, 8'h08, 8'h40},
        '{1'b0, 1'b0, 1'b0,   8'sd0, 1'b0, 8'h0C, 8'h41},
        '{1'b0, 1'b0, 1'b0,   8'sd0, 1'b0, 8'h18, 8'h42},
        '{1'b0, 1'b0, 1'b0,   8'sd5, 1'b1, 8'hFF, 8'h7F},
        '{1'b0, 1'b1, 1'b0,   8'sd3, 1'b1, 8'h55, 8'h00},
        '{1'b1, 1'b1, 1'b1,   8'sd2, 1'b0, 8'hAA, 8'h80}
    };

    posit_packer #(.BITS(8), .ES(1)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv),
        .in_ready  (ir),
        .in_sign   (sgn),
        .in_zero   (zr),
        .in_nar    (nr),
        .in_seed   (seed),
        .in_exp    (ex),
        .in_frac   (fr),
        .out_valid (ov),
        .out_ready (ordy),
        .out_data  (od)
    );

    posit_packer #(.BITS(32), .ES(3)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv32),
        .in_ready  (ir32),
        .in_sign   (sgn32),
        .in_zero   (1'b0),
        .in_nar    (1'b0),
        .in_seed   (seed32),
        .in_exp    (ex32),
        .in_frac   (fr32),
        .out_valid (ov32),
        .out_ready (or32),
        .out_data  (od32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: write the regime/exponent/fraction bit string, cut after BITS-1 bits, round RNE.
    function automatic logic [7:0] model8(input logic s, input logic z, input logic n,
                                          input int k, input int e, input int f);
        logic q[$];
        int   body;
        int   mag;
        logic g;
        logic st;
        if (n) return 8'h80;
        if (z) return 8'h00;
        if (k >= 6) begin
            mag = 127;
        end else if (k <= -7) begin
            mag = 1;
        end else begin
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            q.push_back(e[0]);
            for (int i = 7; i >= 0; i--) q.push_back(f[i]);
            body = 0;
            for (int i = 0; i < 7; i++) body = body * 2 + (q[i] ? 1 : 0);
            g  = q[7];
            st = 1'b0;
            for (int i = 8; i < q.size(); i++) st = st | q[i];
            if (g && (st || (body % 2 == 1))) body++;
            if (body > 127) body = 127;
            if (body == 0) body = 1;
            mag = body;
        end
        return s ? 8'(256 - mag) : 8'(mag);
    endfunction

    function automatic void decode32(input logic [31:0] p, output logic s, output int k,
                                     output int e, output logic [31:0] f);
        logic [31:0] m;
        int          i;
        int          run;
        s   = p[31];
        m   = s ? -p : p;
        i   = 30;
        run = 0;
        while (i >= 0 && m[i] == m[30]) begin
            run++;
            i--;
        end
        k = m[30] ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < 3; j++) begin
            e = e * 2 + ((i >= 0 && m[i]) ? 1 : 0);
            i--;
        end
        f = '0;
        for (int b = 31; b >= 0; b--) begin
            if (i >= 0) f[b] = m[i];
            i--;
        end
    endfunction

    task automatic drive8(input logic s, input logic z, input logic n,
                          input int k, input int e, input int f);
        sgn  = s;
        zr   = z;
        nr   = n;
        seed = 8'(k);
        ex   = 1'(e);
        fr   = 8'(f);
        iv   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ov !== 1'b0 || od !== 8'h00 || ir !== 1'b1 || ov32 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: out_valid=%b out_data=%h in_ready=%b ov32=%b, required 0 00 1 0",
                     ov, od, ir, ov32);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ov !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: out_valid=%b required 0", ov);
        end
    endtask

    task automatic test_directed();
        ordy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 drive8(tbl[i].s, tbl[i].z, tbl[i].n, int'(tbl[i].k), int'(tbl[i].e), int'(tbl[i].f));
            @(posedge clk);
            #1 iv = 1'b0;
            n_cmp++;
            if (ov !== 1'b0) begin
                n_err++;
                $display("FAIL directed[%0d]_latency: out_valid=%b one cycle after accept, required 0", i, ov);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (ov !== 1'b1 || od !== tbl[i].x) begin
                n_err++;
                $display("FAIL directed[%0d]: out_valid=%b out_data=%h, required 1 %h", i, ov, od, tbl[i].x);
            end
        end
    endtask

    task automatic test_backpressure();
        int         ks [4];
        int         fs [4];
        logic [7:0] want [4];
        logic [7:0] got_q [$];
        int         got_cyc [$];
        int         sent;
        int         cyc;
        for (int i = 0; i < 4; i++) begin
            ks[i]   = $urandom_range(0, 8) - 4;
            fs[i]   = $urandom_range(0, 255);
            want[i] = model8(1'b0, 1'b0, 1'b0, ks[i], i % 2, fs[i]);
        end
        ordy = 1'b1;
        @(posedge clk);
        #1 drive8(1'b0, 1'b0, 1'b0, ks[0], 0, fs[0]);
        @(posedge clk);
        #1 drive8(1'b0, 1'b0, 1'b0, ks[1], 1, fs[1]);
        @(posedge clk);
        #1;
        n_cmp++;
        if (ov !== 1'b1 || od !== want[0]) begin
            n_err++;
            $display("FAIL bp_first: out_valid=%b out_data=%h, required 1 %h", ov, od, want[0]);
        end
        ordy = 1'b0;
        drive8(1'b0, 1'b0, 1'b0, ks[2], 0, fs[2]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ov !== 1'b1 || od !== want[0] || ir !== 1'b0) begin
                n_err++;
                $display("FAIL bp_stall[%0d]: out_valid=%b out_data=%h in_ready=%b, required 1 %h 0",
                         c, ov, od, ir, want[0]);
            end
            @(posedge clk);
            #1;
        end
        ordy = 1'b1;
        sent = 2;
        cyc  = 0;
        while (got_q.size() < 4 && cyc < 20) begin
            @(negedge clk);
            if (ov && ordy) begin
                got_q.push_back(od);
                got_cyc.push_back(cyc);
            end
            if (iv && ir) sent++;
            @(posedge clk);
            #1;
            cyc++;
            if (sent < 4) drive8(1'b0, 1'b0, 1'b0, ks[sent], sent % 2, fs[sent]);
            else iv = 1'b0;
        end
        iv = 1'b0;
        n_cmp++;
        if (got_q.size() != 4) begin
            n_err++;
            $display("FAIL bp_count: received %0d words, required 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_q[i] !== want[i]) begin
                    n_err++;
                    $display("FAIL bp_order[%0d]: out_data=%h, required %h", i, got_q[i], want[i]);
                end
            end
            n_cmp++;
            if (got_cyc[3] - got_cyc[0] != 3) begin
                n_err++;
                $display("FAIL bp_throughput: 4 words over %0d cycles, required 3", got_cyc[3] - got_cyc[0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_inflight();
        logic [7:0] want;
        ordy = 1'b1;
        @(posedge clk);
        #1 drive8(1'b0, 1'b0, 1'b0, 1, 1, 8'h3C);
        @(posedge clk);
        #1 drive8(1'b1, 1'b0, 1'b0, -2, 0, 8'hC3);
        @(posedge clk);
        #1 iv = 1'b0;
        ordy = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ov !== 1'b0 || od !== 8'h00) begin
            n_err++;
            $display("FAIL reset_async: out_valid=%b out_data=%h, required 0 00", ov, od);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        ordy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ov !== 1'b0) begin
                n_err++;
                $display("FAIL reset_stale[%0d]: out_valid=%b out_data=%h, required 0", c, ov, od);
            end
        end
        want = model8(1'b0, 1'b0, 1'b0, -1, 1, 8'h80);
        @(posedge clk);
        #1 drive8(1'b0, 1'b0, 1'b0, -1, 1, 8'h80);
        @(posedge clk);
        #1 iv = 1'b0;
        n_cmp++;
        if (ov !== 1'b0) begin
            n_err++;
            $display("FAIL reset_relatency_early: out_valid=%b required 0", ov);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (ov !== 1'b1 || od !== want) begin
            n_err++;
            $display("FAIL reset_first_word: out_valid=%b out_data=%h, required 1 %h", ov, od, want);
        end
    endtask

    task automatic test_random_stream(input int n);
        logic       rs [$];
        logic       rz [$];
        logic       rn [$];
        int         rk [$];
        int         re [$];
        int         rf [$];
        logic [7:0] want [$];
        int         sent;
        int         got;
        int         cyc;
        logic       prev_stall;
        logic [7:0] prev_data;
        for (int i = 0; i < n; i++) begin
            rs.push_back(1'($urandom_range(0, 1)));
            rz.push_back($urandom_range(0, 15) == 0);
            rn.push_back($urandom_range(0, 15) == 0);
            rk.push_back($urandom_range(0, 18) - 9);
            re.push_back($urandom_range(0, 1));
            rf.push_back($urandom_range(0, 255));
            want.push_back(model8(rs[i], rz[i], rn[i], rk[i], re[i], rf[i]));
        end
        sent       = 0;
        got        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        @(posedge clk);
        #1;
        while (got < n && cyc < 4000) begin
            if (sent < n) drive8(rs[sent], rz[sent], rn[sent], rk[sent], re[sent], rf[sent]);
            else iv = 1'b0;
            ordy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++;
                if (ov !== 1'b1 || od !== prev_data) begin
                    n_err++;
                    $display("FAIL rand_hold: out_valid=%b out_data=%h, required 1 %h", ov, od, prev_data);
                end
            end
            prev_stall = ov && !ordy;
            prev_data  = od;
            if (ov && ordy) begin
                n_cmp++;
                if (od !== want[got]) begin
                    n_err++;
                    $display("FAIL rand_word[%0d]: out_data=%h, required %h", got, od, want[got]);
                end
                got++;
            end
            if (iv && ir) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        iv   = 1'b0;
        ordy = 1'b1;
        n_cmp++;
        if (got != n) begin
            n_err++;
            $display("FAIL rand_timeout: received %0d words, required %0d", got, n);
        end
    endtask

    task automatic test_roundtrip32(input int n);
        int          k, e, rlen, nf;
        logic        s;
        logic [31:0] f;
        logic        ds;
        int          dk, de;
        logic [31:0] df;
        or32 = 1'b1;
        for (int i = 0; i < n; i++) begin
            k    = $urandom_range(0, 40) - 20;
            e    = $urandom_range(0, 7);
            s    = 1'($urandom_range(0, 1));
            rlen = (k >= 0) ? k + 2 : 1 - k;
            nf   = 31 - rlen - 3;
            f    = $urandom & ~(32'hFFFF_FFFF >> nf);
            @(posedge clk);
            #1;
            sgn32  = s;
            seed32 = 32'(k);
            ex32   = 3'(e);
            fr32   = f;
            iv32   = 1'b1;
            @(posedge clk);
            #1 iv32 = 1'b0;
            @(posedge clk);
            #1;
            decode32(od32, ds, dk, de, df);
            n_cmp++;
            if (ov32 !== 1'b1 || ds !== s || dk != k || de != e || df !== f) begin
                n_err++;
                $display("FAIL roundtrip32[%0d]: word=%h valid=%b got s=%b k=%0d e=%0d f=%h, required s=%b k=%0d e=%0d f=%h",
                         i, od32, ov32, ds, dk, de, df, s, k, e, f);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        iv     = 1'b0;
        ordy   = 1'b1;
        sgn    = 1'b0;
        zr     = 1'b0;
        nr     = 1'b0;
        seed   = '0;
        ex     = '0;
        fr     = '0;
        iv32   = 1'b0;
        or32   = 1'b1;
        sgn32  = 1'b0;
        seed32 = '0;
        ex32   = '0;
        fr32   = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_inflight();
        test_random_stream(300);
        test_roundtrip32(100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
